// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: request, response and memory-port signals of the read arbiter
interface mem_read_arbiter_if #(
  parameter int AddrWidth = 32,
  parameter int LineSize  = 128
);
  logic [AddrWidth-1:0] req0_addr_i;
  logic                 req0_read_en_i;
  logic                 req0_read_valid_o;
  logic [AddrWidth-1:0] req1_addr_i;
  logic                 req1_read_en_i;
  logic                 req1_read_valid_o;
  logic [LineSize-1:0]  read_data_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic                 mem_read_en_o;
  logic                 mem_read_valid_i;
  logic [LineSize-1:0]  mem_read_data_i;
  logic                 owner_o;
  logic                 busy_o;
  modport slave (
    input  req0_addr_i, req0_read_en_i, req1_addr_i, req1_read_en_i,
    input  mem_read_valid_i, mem_read_data_i,
    output req0_read_valid_o, req1_read_valid_o, read_data_o,
    output mem_addr_o, mem_read_en_o, owner_o, busy_o
  );
  modport master (
    output req0_addr_i, req0_read_en_i, req1_addr_i, req1_read_en_i,
    output mem_read_valid_i, mem_read_data_i,
    input  req0_read_valid_o, req1_read_valid_o, read_data_o,
    input  mem_addr_o, mem_read_en_o, owner_o, busy_o
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one line-wide memory read port between two caches
module mem_read_arbiter #(
  parameter int AddrWidth      = 32,
  parameter int ByteOffsetBits = 4,
  parameter int LineSize       = 8 * (2 ** ByteOffsetBits)
) (
  input logic clk_i,
  input logic rstn_i,
  mem_read_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam logic [AddrWidth-1:0] LineMask = {{(AddrWidth-ByteOffsetBits){1'b1}}, {ByteOffsetBits{1'b0}}};
  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LineSize-1:0]  data_q, data_d;
  logic                 winner;
  logic                 owner_en;
  assign winner   = (bus.req0_read_en_i && bus.req1_read_en_i) ? ~last_q : bus.req1_read_en_i;
  assign owner_en = owner_q ? bus.req1_read_en_i : bus.req0_read_en_i;
  // next-state: grant in IDLE, capture the line in BUSY, single response cycle in RESP
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (bus.req0_read_en_i || bus.req1_read_en_i) begin
        state_d = BUSY;
        owner_d = winner;
        addr_d  = (winner ? bus.req1_addr_i : bus.req0_addr_i) & LineMask;
      end
      BUSY: if (bus.mem_read_valid_i) begin
        state_d = owner_en ? RESP : IDLE;
        data_d  = bus.mem_read_data_i;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and latches; last_q starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign bus.mem_read_en_o     = state_q == BUSY;
  assign bus.mem_addr_o        = state_q == BUSY ? addr_q : '0;
  assign bus.req0_read_valid_o = state_q == RESP && !owner_q;
  assign bus.req1_read_valid_o = state_q == RESP && owner_q;
  assign bus.read_data_o       = state_q == RESP ? data_q : '0;
  assign bus.owner_o           = owner_q;
  assign bus.busy_o            = state_q != IDLE;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: directed and random checks of mem_read_arbiter against a transaction-level model
module tb_mem_read_arbiter;
  logic clk_i;
  logic rstn_i;
  mem_read_arbiter_if #(.AddrWidth(32), .LineSize(128)) bus ();
  mem_read_arbiter #(.AddrWidth(32), .ByteOffsetBits(4), .LineSize(128)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .bus(bus)
  );
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic en0, en1, mv;
  logic [31:0] a0, a1;
  logic [127:0] md;
  bit auto_mem;
  int lat;
  bit m_fetch, m_deliver, m_who, m_last;
  int m_age;
  logic [31:0] m_addr;
  logic [127:0] m_data;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    m_fetch = 0; m_deliver = 0; m_who = 0; m_last = 1; m_age = 0;
    m_addr = '0; m_data = '0;
  endtask
  // one transaction at a time: grant when free, fetch until memory answers, then one delivery cycle
  task automatic model_step();
    if (m_deliver) m_deliver = 0;
    else if (m_fetch) begin
      if (mv) begin
        m_last = m_who;
        m_fetch = 0;
        if (m_who ? en1 : en0) begin
          m_deliver = 1;
          m_data = md;
        end
      end else m_age++;
    end else if (en0 || en1) begin
      m_who = (en0 && en1) ? !m_last : en1;
      m_addr = (m_who ? a1 : a0) & ~32'hF;
      m_fetch = 1;
      m_age = 1;
    end
  endtask
  task automatic check_all();
    chk("mem_read_en", bus.mem_read_en_o, m_fetch);
    chk("mem_addr", bus.mem_addr_o, m_fetch ? m_addr : 32'h0);
    chk("req0_valid", bus.req0_read_valid_o, m_deliver && !m_who);
    chk("req1_valid", bus.req1_read_valid_o, m_deliver && m_who);
    chk("read_data", bus.read_data_o, m_deliver ? m_data : 128'h0);
    chk("busy", bus.busy_o, m_fetch || m_deliver);
    chk("owner", bus.owner_o, m_who);
  endtask
  task automatic drive();
    bus.req0_addr_i = a0; bus.req0_read_en_i = en0;
    bus.req1_addr_i = a1; bus.req1_read_en_i = en1;
    bus.mem_read_valid_i = mv; bus.mem_read_data_i = md;
  endtask
  task automatic tick();
    if (auto_mem) begin
      mv = m_fetch && m_age >= lat + 1;
      md = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    drive();
    model_step();
    @(negedge clk_i);
    cyc++;
    check_all();
  endtask
  task automatic do_reset();
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk_i);
    check_all();
    rstn_i = 1'b1;
  endtask
  int t_en, t_v, nv;
  logic [31:0] got_addr;
  logic [31:0] addr_log[$];
  bit who_log[$];
  initial begin
    en0 = 0; en1 = 0; mv = 0; a0 = '0; a1 = '0; md = '0; auto_mem = 1; lat = 2;
    drive();
    rstn_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    check_all();
    rstn_i = 1'b1;
    // single requester, memory latency 2
    en0 = 1; a0 = 32'h0000_1234; t_en = -1; t_v = -1;
    for (int i = 0; i < 12 && t_v < 0; i++) begin
      tick();
      if (bus.mem_read_en_o && t_en < 0) begin t_en = cyc; got_addr = bus.mem_addr_o; end
      if (m_deliver) begin t_v = cyc; en0 = 0; end
    end
    chk("t1_addr", got_addr, 32'h0000_1230);
    chk("t1_latency", t_v - t_en, 3);
    repeat (2) tick();
    // both requesting from reset, latency 1: strict alternation
    do_reset();
    en0 = 1; en1 = 1; a0 = 32'h100; a1 = 32'h200; lat = 1; nv = 0;
    for (int i = 0; i < 40 && who_log.size() < 4; i++) begin
      tick();
      if (bus.mem_read_en_o && m_age == 1) addr_log.push_back(bus.mem_addr_o);
      if (m_deliver) who_log.push_back(m_who);
    end
    en0 = 0; en1 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr_seq", addr_log.size() > i ? addr_log[i] : 32'hFFFF_FFFF, i % 2 ? 32'h200 : 32'h100);
      chk("t2_valid_seq", who_log.size() > i ? who_log[i] : 1'bx, i % 2);
    end
    repeat (2) tick();
    // address change after grant is ignored
    en0 = 1; a0 = 32'h040; lat = 3; t_v = -1;
    tick();
    a0 = 32'h880;
    for (int i = 0; i < 10 && t_v < 0; i++) begin
      if (m_fetch) chk("t3_addr_hold", bus.mem_addr_o, 32'h040);
      tick();
      if (m_deliver) begin t_v = cyc; en0 = 0; end
    end
    chk("t3_served", t_v > 0, 1);
    tick();
    // req1 wins the tie, withdraws during BUSY, req0 then gets the port
    auto_mem = 0; mv = 0; en0 = 1; en1 = 1; a0 = 32'h500; a1 = 32'h300;
    tick();
    chk("t4_owner1", bus.owner_o, 1'b1);
    en1 = 0;
    tick();
    mv = 1; md = {4{32'hDEAD_BEEF}};
    tick();
    chk("t4_busy_drop", bus.busy_o, 1'b0);
    chk("t4_no_pulse", {bus.req0_read_valid_o, bus.req1_read_valid_o}, 2'b00);
    mv = 0;
    tick();
    chk("t4_regrant_addr", bus.mem_addr_o, 32'h500);
    auto_mem = 1; lat = 1; t_v = -1;
    for (int i = 0; i < 10 && t_v < 0; i++) begin
      tick();
      if (m_deliver) begin t_v = cyc; en0 = 0; end
    end
    chk("t4_req0_served", t_v > 0, 1);
    tick();
    // asynchronous reset in the middle of a fetch
    auto_mem = 0; mv = 0; en0 = 1; a0 = 32'h600;
    tick();
    chk("t5_in_busy", bus.mem_read_en_o, 1'b1);
    en0 = 0;
    do_reset();
    mv = 1;
    tick();
    mv = 0;
    tick();
    en0 = 1; en1 = 1; a0 = 32'h700; a1 = 32'h800;
    tick();
    chk("t5_owner0_first", bus.owner_o, 1'b0);
    auto_mem = 1; lat = 2; nv = 0;
    for (int i = 0; i < 30 && nv < 2; i++) begin
      tick();
      if (m_deliver) begin
        nv++;
        if (m_who) en1 = 0; else en0 = 0;
      end
    end
    chk("t5_both_served", nv, 2);
    // spurious memory valid while idle
    auto_mem = 0; en0 = 0; en1 = 0; mv = 1;
    repeat (3) tick();
    chk("t6_idle_busy", bus.busy_o, 1'b0);
    mv = 0;
    tick();
    // random traffic with random memory latency and spurious valids
    for (int i = 0; i < 600; i++) begin
      mv = m_fetch ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      md = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (!en0) begin if ($urandom_range(0, 2) == 0) begin en0 = 1; a0 = $urandom(); end end
      else if ($urandom_range(0, 3) == 0) a0 = $urandom();
      else if ($urandom_range(0, 19) == 0) en0 = 0;
      if (!en1) begin if ($urandom_range(0, 2) == 0) begin en1 = 1; a1 = $urandom(); end end
      else if ($urandom_range(0, 3) == 0) a1 = $urandom();
      else if ($urandom_range(0, 19) == 0) en1 = 0;
      tick();
      if (m_deliver && $urandom_range(0, 1) == 0) begin
        if (m_who) en1 = 0; else en0 = 0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single line-wide memory read port between two cache clients: requester 0 is the instruction cache, requester 1 is the data cache.
- Arbitrates round-robin and latches the winner's line address at grant, so the address is stable for the whole transaction.
- Returns the fetched line to the owner with a one-cycle valid pulse.
- Sits between the caches' mem_* ports and the memory model/controller.

Parameters:
- AddrWidth, 32, address width in bits.
- ByteOffsetBits, 4, line offset bits; forced to zero on the memory address.
- LineSize, 128, bits per cache line (= 8 * 2**ByteOffsetBits).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- req0_addr_i  in  AddrWidth  requester 0 address
- req0_read_en_i  in  1  requester 0 read request (level)
- req0_read_valid_o  out  1  requester 0 line valid (1-cycle pulse)
- req1_addr_i  in  AddrWidth  requester 1 address
- req1_read_en_i  in  1  requester 1 read request (level)
- req1_read_valid_o  out  1  requester 1 line valid (1-cycle pulse)
- read_data_o  out  LineSize  returned line, shared by both requesters
- mem_addr_o  out  AddrWidth  line-aligned memory address
- mem_read_en_o  out  1  memory read request
- mem_read_valid_i  in  1  memory data valid
- mem_read_data_i  in  LineSize  memory line data
- owner_o  out  1  current/last grant index (debug)
- busy_o  out  1  high when state != IDLE

Behaviour:
- Reset (async, rstn_i=0):
  - state=IDLE, owner_o=0, last_served=1.
  - Address and data latches cleared.
  - All outputs 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If no read_en: stay in IDLE.
  - One read_en high: grant that requester.
  - Both high: grant the requester != last_served.
  - On grant: owner<=winner, addr_q<=winner addr with the low ByteOffsetBits zeroed, next state BUSY.
- BUSY:
  - mem_read_en_o=1, mem_addr_o=addr_q; both are held until mem_read_valid_i.
  - On mem_read_valid_i=1: data_q<=mem_read_data_i, last_served<=owner.
  - Next state is RESP if the owner's read_en is still high; otherwise IDLE, with the data discarded and no pulse.
- RESP:
  - Owner's read_valid_o=1 for exactly one cycle; read_data_o=data_q.
  - Next state IDLE unconditionally.
  - A new grant is made in the following IDLE cycle; there is no back-to-back RESP→BUSY path.
- Outside BUSY: mem_read_en_o=0, mem_addr_o=0.
- Outside RESP: both read_valid_o=0 and read_data_o=0.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_read_en_o at cycle 1.
  - mem_read_valid_i at cycle k (k≥1) → read_valid_o at cycle k+1.
  - Minimum request-to-valid: 2 cycles.
  - Minimum throughput: one line per 3 cycles.
- Address changes by a requester after grant are ignored until its next grant.
- Requester protocol:
  - Hold read_en_i high until read_valid_o.
  - A requester still holding read_en_i in the cycle after RESP is re-arbitrated as a new request.
- Withdrawn request (owner read_en_i drops in BUSY): the memory transaction still completes, and the response is silently dropped.
- The non-owner's request waits; it is never lost while its read_en_i stays high.
- mem_read_valid_i outside BUSY is ignored.
- Starvation bound: with both requesters continuously requesting, grants strictly alternate 0,1,0,1...
- Reset mid-transaction: immediate return to IDLE with all outputs 0. A memory response arriving after reset is ignored.

Test Plan:
- Reset, then req0 alone with addr 0x0000_1234; memory valid 2 cycles after mem_read_en_o with data 0xDDDD_CCCC_BBBB_AAAA... → mem_addr_o=0x0000_1230; req0_read_valid_o pulses once, 3 cycles after mem_read_en_o rose, with read_data_o equal to that line; req1_read_valid_o stays 0.
- Both requests asserted together from reset (req0 0x100, req1 0x200), memory latency 1 → mem_addr_o sequence 0x100, 0x200, 0x100, 0x200; valids alternate req0, req1.
- req0 changes its address from 0x040 to 0x880 during BUSY → mem_addr_o stays 0x040 and the returned line belongs to 0x040.
- req1 granted, then drops read_en in BUSY; memory returns valid → no read_valid pulse; busy_o=0 on the next cycle; pending req0 is granted in the following IDLE.
- rstn_i pulsed low during BUSY with mem_read_en_o=1 → all outputs 0 immediately; a mem_read_valid_i after reset produces no pulse; the next request is served normally with owner 0 first.
- Spurious mem_read_valid_i=1 while IDLE → no state change and no valid pulse.
